bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_updown_counter.sv | 116 +++++++++++
 tb/tb_bcd_updown_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// bcd_updown_counter : multi-digit BCD up/down counter with limit, load, wrap
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_updown_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  ud,
  input  logic                  wrap,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  err
);

  localparam int c_W = 4 * DIGITS;

  logic [c_W-1:0]    r_count;
  logic              r_tc;
  logic              r_err;

  logic [c_W-1:0]    w_inc;
  logic [c_W-1:0]    w_dec;
  logic [DIGITS-1:0] w_carry;
  logic [DIGITS-1:0] w_borrow;
  logic [DIGITS-1:0] w_lim_bad;
  logic [DIGITS-1:0] w_ld_bad;
  logic [c_W-1:0]    w_next_count;
  logic              w_next_tc;
  logic              w_next_err;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_cur;
      assign w_cur         = r_count[4*gi +: 4];
      assign w_lim_bad[gi] = (limit[4*gi +: 4] > 4'd9);
      assign w_ld_bad[gi]  = (load_val[4*gi +: 4] > 4'd9);

      // Carry/borrow into a digit is set only when every lower digit rolls over.
      if (gi == 0) begin : g_first
        assign w_carry[gi]  = 1'b1;
        assign w_borrow[gi] = 1'b1;
      end else begin : g_rest
        assign w_carry[gi]  = w_carry[gi-1]  & (r_count[4*gi-4 +: 4] == 4'd9);
        assign w_borrow[gi] = w_borrow[gi-1] & (r_count[4*gi-4 +: 4] == 4'd0);
      end

      assign w_inc[4*gi +: 4] = !w_carry[gi]  ? w_cur :
                                (w_cur == 4'd9) ? 4'd0 : w_cur + 4'd1;
      assign w_dec[4*gi +: 4] = !w_borrow[gi] ? w_cur :
                                (w_cur == 4'd0) ? 4'd9 : w_cur - 4'd1;
    end
  endgenerate

  // Binary magnitude compare is valid here because both operands are legal BCD.
  always_comb begin
    w_next_count = r_count;
    w_next_tc    = 1'b0;
    w_next_err   = 1'b0;
    if (|w_lim_bad) begin
      w_next_err = 1'b1;
    end else if (load) begin
      if ((|w_ld_bad) || (load_val > limit)) begin
        w_next_err = 1'b1;
      end else begin
        w_next_count = load_val;
      end
    end else if (en) begin
      if (r_count > limit) begin
        w_next_count = (ud && wrap) ? '0 : limit;
        w_next_tc    = 1'b1;
      end else if (ud) begin
        if (r_count == limit) begin
          w_next_count = wrap ? '0 : r_count;
          w_next_tc    = 1'b1;
        end else begin
          w_next_count = w_inc;
        end
      end else begin
        if (r_count == '0) begin
          w_next_count = wrap ? limit : '0;
          w_next_tc    = 1'b1;
        end else begin
          w_next_count = w_dec;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_tc    <= w_next_tc;
      r_err   <= w_next_err;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_bcd_updown_counter : vector table plus scoreboard bench for 2- and 4-digit counters
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_updown_counter;

  logic        clock;
  logic        reset, en, ud, wrap, load;
  logic [7:0]  load_val, limit;
  logic [7:0]  count;
  logic        tc, err;

  logic        reset4, en4, ud4, wrap4, load4;
  logic [15:0] load_val4, limit4;
  logic [15:0] count4;
  logic        tc4, err4;

  int total = 0;
  int bad   = 0;

  bcd_updown_counter #(.DIGITS(2)) dut2 (
    .clock(clock), .reset(reset), .en(en), .ud(ud), .wrap(wrap), .load(load),
    .load_val(load_val), .limit(limit), .count(count), .tc(tc), .err(err)
  );

  bcd_updown_counter #(.DIGITS(4)) dut4 (
    .clock(clock), .reset(reset4), .en(en4), .ud(ud4), .wrap(wrap4), .load(load4),
    .load_val(load_val4), .limit(limit4), .count(count4), .tc(tc4), .err(err4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sel4;
    logic [15:0] cnt;
    logic        tc;
    logic        err;
    int          tag;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic       rn, e, u, w, l;
    logic [7:0] lv, lim;
    logic [7:0] ec;
    logic       et, ee;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rn, e, u, w, l, input logic [7:0] lv, lim, ec,
                     input logic et, ee);
    vec_t v;
    v.rn = rn; v.e = e; v.u = u; v.w = w; v.l = l;
    v.lv = lv; v.lim = lim; v.ec = ec; v.et = et; v.ee = ee;
    vt.push_back(v);
  endtask

  task automatic check_one(input string nm, input int tag, input logic [15:0] got,
                           input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, tag, got, want);
    end
  endtask

  task automatic compare_out();
    exp_t x;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty got=0 want=1");
      return;
    end
    x = sb.pop_front();
    if (x.sel4) begin
      check_one("count4", x.tag, count4, x.cnt);
      check_one("tc4", x.tag, {15'd0, tc4}, {15'd0, x.tc});
      check_one("err4", x.tag, {15'd0, err4}, {15'd0, x.err});
    end else begin
      check_one("count", x.tag, {8'd0, count}, x.cnt);
      check_one("tc", x.tag, {15'd0, tc}, {15'd0, x.tc});
      check_one("err", x.tag, {15'd0, err}, {15'd0, x.err});
    end
  endtask

  task automatic step2(input logic rn, e, u, w, l, input logic [7:0] lv, lim, ec,
                       input logic et, ee, input int tag);
    exp_t x;
    reset = rn; en = e; ud = u; wrap = w; load = l; load_val = lv; limit = lim;
    x.sel4 = 1'b0; x.cnt = {8'd0, ec}; x.tc = et; x.err = ee; x.tag = tag;
    sb.push_back(x);
    @(posedge clock);
    #1;
    compare_out();
  endtask

  task automatic step4(input logic rn, e, u, w, l, input logic [15:0] lv, ec,
                       input logic et, ee, input int tag);
    exp_t x;
    reset4 = rn; en4 = e; ud4 = u; wrap4 = w; load4 = l; load_val4 = lv;
    limit4 = 16'h9999;
    x.sel4 = 1'b1; x.cnt = ec; x.tc = et; x.err = ee; x.tag = tag;
    sb.push_back(x);
    @(posedge clock);
    #1;
    compare_out();
  endtask

  initial begin
    int m;
    logic [7:0] ec;
    clock = 1'b0;
    reset = 1'b0; en = 1'b0; ud = 1'b0; wrap = 1'b0; load = 1'b0;
    load_val = 8'h00; limit = 8'h59;
    reset4 = 1'b0; en4 = 1'b0; ud4 = 1'b0; wrap4 = 1'b0; load4 = 1'b0;
    load_val4 = 16'h0000; limit4 = 16'h9999;

    // rn  en ud wr ld  lv     lim    count  tc err
    add(1, 0, 0, 0, 1, 8'h10, 8'h59, 8'h10, 0, 0);
    add(1, 1, 0, 0, 0, 8'h00, 8'h59, 8'h09, 0, 0);
    add(1, 1, 0, 0, 0, 8'h00, 8'h59, 8'h08, 0, 0);
    add(1, 1, 1, 1, 1, 8'h00, 8'h59, 8'h00, 0, 0);
    add(1, 1, 0, 0, 0, 8'h00, 8'h59, 8'h00, 1, 0);
    add(1, 1, 0, 0, 0, 8'h00, 8'h59, 8'h00, 1, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h59, 8'h00, 0, 0);
    add(1, 1, 0, 1, 0, 8'h00, 8'h59, 8'h59, 1, 0);
    add(1, 1, 1, 0, 0, 8'h00, 8'h59, 8'h59, 1, 0);
    add(1, 1, 1, 0, 0, 8'h00, 8'h59, 8'h59, 1, 0);
    add(1, 0, 0, 0, 1, 8'h5A, 8'h59, 8'h59, 0, 1);
    add(1, 0, 0, 0, 1, 8'h60, 8'h59, 8'h59, 0, 1);
    add(1, 0, 0, 0, 1, 8'h42, 8'h59, 8'h42, 0, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h59, 8'h42, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h59, 8'h43, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h59, 8'h44, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h59, 8'h45, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h30, 8'h00, 1, 0);
    add(1, 0, 0, 0, 1, 8'h45, 8'h59, 8'h45, 0, 0);
    add(1, 1, 0, 1, 0, 8'h00, 8'h30, 8'h30, 1, 0);
    add(1, 1, 1, 0, 0, 8'h00, 8'h30, 8'h30, 1, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h3F, 8'h30, 0, 1);
    add(1, 1, 1, 1, 1, 8'h10, 8'h3F, 8'h30, 0, 1);
    add(1, 1, 1, 1, 0, 8'h00, 8'h59, 8'h31, 0, 0);
    add(1, 1, 0, 1, 0, 8'h00, 8'h59, 8'h30, 0, 0);
    add(1, 0, 0, 0, 1, 8'h59, 8'h59, 8'h59, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0);
    add(0, 1, 1, 1, 1, 8'h42, 8'h59, 8'h00, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h59, 8'h01, 0, 0);

    // Reset held low for two edges, with load/en active to show it overrides them.
    step2(0, 1, 1, 1, 1, 8'h42, 8'h59, 8'h00, 0, 0, 1000);
    step2(0, 1, 1, 1, 1, 8'h42, 8'h59, 8'h00, 0, 0, 1001);

    // Free-running up count with wrap: expected value derived from the edge index.
    for (int k = 1; k <= 61; k++) begin
      m  = k % 60;
      ec = 8'(((m / 10) * 16) + (m % 10));
      step2(1, 1, 1, 1, 0, 8'h00, 8'h59, ec, (m == 0), 0, 2000 + k);
    end

    for (int i = 0; i < vt.size(); i++) begin
      step2(vt[i].rn, vt[i].e, vt[i].u, vt[i].w, vt[i].l, vt[i].lv, vt[i].lim,
            vt[i].ec, vt[i].et, vt[i].ee, i);
    end

    // Four-digit ripple carry and borrow, then wrap from 9999 and reset during load.
    step4(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 4000);
    step4(1, 0, 0, 0, 1, 16'h0999, 16'h0999, 0, 0, 4001);
    step4(1, 1, 1, 1, 0, 16'h0000, 16'h1000, 0, 0, 4002);
    step4(1, 1, 0, 1, 0, 16'h0000, 16'h0999, 0, 0, 4003);
    step4(1, 0, 0, 0, 1, 16'h9999, 16'h9999, 0, 0, 4004);
    step4(1, 1, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, 4005);
    step4(1, 1, 1, 1, 0, 16'h0000, 16'h0001, 0, 0, 4006);
    step4(1, 0, 0, 0, 1, 16'h5A00, 16'h0001, 0, 1, 4007);
    step4(0, 1, 1, 1, 1, 16'h0999, 16'h0000, 0, 0, 4008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
